// File: rtl/pipreg_if_id_queue.sv
// ---------------------------------------------------------------------------
// pipreg_if_id_queue
//   DEPTH-entry instruction queue between fetch (IF) and decode (ID).
//   The head entry is presented with pre-extracted decode fields. An empty or
//   cleared queue presents a NOP bubble with zeroed fields.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   address_rst,flush synchronous clear (both have the same effect)
//   in_valid/in_ready fetch-side handshake; PC_added, Icache_out payload
//   out_valid/out_ready decode-side handshake
//   PC_added_ID, instruction, Read_addr_1_ID, Read_addr_2_ID,
//   write_addr_ID, csr_addr_ID, imm_in   head fields (gated by out_valid)
//   count             current occupancy
// ---------------------------------------------------------------------------
module pipreg_if_id_queue #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 4,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           address_rst,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_W-1:0]              PC_added,
   input  logic [DATA_W-1:0]              Icache_out,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              PC_added_ID,
   output logic [DATA_W-1:0]              instruction,
   output logic [4:0]                     Read_addr_1_ID,
   output logic [4:0]                     Read_addr_2_ID,
   output logic [4:0]                     write_addr_ID,
   output logic [11:0]                    csr_addr_ID,
   output logic [DATA_W-1:0]              imm_in,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          clear, enq, deq;
   entry_t        head;

   // Handshake status depends only on registered occupancy (no out_ready -> in_ready path)
   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign clear     = flush | address_rst;
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;

   // Next-state for pointers and occupancy; clear overrides any transfer
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage: contents are don't-care after reset, so no reset branch
   always_ff @(posedge clk) begin
      if (enq && !clear) begin
         mem_q[wr_ptr_q] <= '{pc: PC_added, instr: Icache_out};
      end
   end

   // Head decode, gated so an empty queue shows the NOP bubble
   assign head = mem_q[rd_ptr_q];

   always_comb begin
      PC_added_ID    = '0;
      instruction    = NOP_INSTR;
      Read_addr_1_ID = '0;
      Read_addr_2_ID = '0;
      write_addr_ID  = '0;
      csr_addr_ID    = '0;
      imm_in         = '0;
      if (out_valid) begin
         PC_added_ID    = head.pc;
         instruction    = head.instr;
         Read_addr_1_ID = head.instr[19:15];
         Read_addr_2_ID = head.instr[24:20];
         write_addr_ID  = head.instr[11:7];
         csr_addr_ID    = head.instr[31:20];
         imm_in         = head.instr;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_pipreg_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_pipreg_if_id_queue
//   Self-checking bench for pipreg_if_id_queue. A queue of {pc,instr} pairs
//   models the expected FIFO contents; head fields are derived from it.
// ---------------------------------------------------------------------------
module tb_pipreg_if_id_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        address_rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] PC_added = '0;
   logic [31:0] Icache_out = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] PC_added_ID;
   logic [31:0] instruction;
   logic [4:0]  Read_addr_1_ID;
   logic [4:0]  Read_addr_2_ID;
   logic [4:0]  write_addr_ID;
   logic [11:0] csr_addr_ID;
   logic [31:0] imm_in;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   logic [63:0] mq[$];

   pipreg_if_id_queue #(.DATA_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .address_rst(address_rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .PC_added(PC_added), .Icache_out(Icache_out),
      .out_ready(out_ready), .out_valid(out_valid),
      .PC_added_ID(PC_added_ID), .instruction(instruction),
      .Read_addr_1_ID(Read_addr_1_ID), .Read_addr_2_ID(Read_addr_2_ID),
      .write_addr_ID(write_addr_ID), .csr_addr_ID(csr_addr_ID),
      .imm_in(imm_in), .count(count)
   );

   always #5 clk = ~clk;

   // Model view of the head
   function automatic logic m_valid();
      return mq.size() != 0;
   endfunction
   function automatic logic [31:0] m_raw();
      if (mq.size() != 0) return mq[0][31:0];
      return 32'h0;
   endfunction
   function automatic logic [31:0] m_pc();
      if (mq.size() != 0) return mq[0][63:32];
      return 32'h0;
   endfunction

   // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge
   task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic ar);
      logic do_enq, do_deq, clr;
      in_valid = iv; PC_added = pc; Icache_out = ins;
      out_ready = ordy; flush = fl; address_rst = ar;
      clr    = fl | ar;
      do_enq = iv && (mq.size() < DEPTH);
      do_deq = (mq.size() != 0) && ordy;
      @(posedge clk);
      if (clr) mq.delete();
      else begin
         if (do_deq) mq.delete(0);
         if (do_enq) mq.push_back({pc, ins});
      end
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0; address_rst = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || instruction !== NOP) begin
         errors++;
         $display("FAIL reset_held valid=%b count=%0d instr=%h exp 0/0/%h", out_valid, count, instruction, NOP);
      end
      rst = 1'b0;
      mq.delete();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL reset_status valid=%b ready=%b count=%0d exp 0/1/0", out_valid, in_ready, count);
      end
      checks++;
      if (instruction !== NOP || PC_added_ID !== 32'h0 || imm_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_data instr=%h pc=%h imm=%h exp %h/0/0", instruction, PC_added_ID, imm_in, NOP);
      end
      checks++;
      if (Read_addr_1_ID !== 5'd0 || Read_addr_2_ID !== 5'd0 || write_addr_ID !== 5'd0 || csr_addr_ID !== 12'd0) begin
         errors++;
         $display("FAIL reset_fields ra1=%0d ra2=%0d wa=%0d csr=%h exp all 0", Read_addr_1_ID, Read_addr_2_ID, write_addr_ID, csr_addr_ID);
      end
   endtask

   task automatic test_pass_through();
      step(1'b1, 32'h4, 32'h0020_8033, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || instruction !== 32'h0020_8033 || PC_added_ID !== 32'h4 || count !== 3'd1) begin
         errors++;
         $display("FAIL pass_head valid=%b instr=%h pc=%h count=%0d exp 1/00208033/4/1", out_valid, instruction, PC_added_ID, count);
      end
      checks++;
      if (Read_addr_1_ID !== 5'd1 || Read_addr_2_ID !== 5'd2 || write_addr_ID !== 5'd0 || csr_addr_ID !== 12'h002) begin
         errors++;
         $display("FAIL pass_fields ra1=%0d ra2=%0d wa=%0d csr=%h exp 1/2/0/002", Read_addr_1_ID, Read_addr_2_ID, write_addr_ID, csr_addr_ID);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pass_drain count=%0d valid=%b exp 0/0", count, out_valid);
      end
   endtask

   task automatic test_fill_stall();
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
         if (i >= 4) begin
            checks++;
            if (count !== 3'd4 || in_ready !== 1'b0 || PC_added_ID !== 32'h4) begin
               errors++;
               $display("FAIL fill_full_%0d count=%0d ready=%b headpc=%h exp 4/0/4", i, count, in_ready, PC_added_ID);
            end
         end
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (PC_added_ID !== 32'(4 * i) || instruction !== m_raw()) begin
            errors++;
            $display("FAIL drain_order_%0d pc=%h instr=%h exp %h/%h", i, PC_added_ID, instruction, 32'(4 * i), m_raw());
         end
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL drain_empty valid=%b count=%0d exp 0/0", out_valid, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc = 32'h100;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, pc, $urandom, 1'b0, 1'b0, 1'b0);
         pc += 4;
      end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp_pc;
         exp_pc = 32'h100 + 32'(4 * i);
         checks++;
         if (count !== 3'd2 || PC_added_ID !== exp_pc || instruction !== m_raw()) begin
            errors++;
            $display("FAIL b2b_%0d count=%0d pc=%h instr=%h exp 2/%h/%h", i, count, PC_added_ID, instruction, exp_pc, m_raw());
         end
         step(1'b1, pc, $urandom, 1'b1, 1'b0, 1'b0);
         pc += 4;
      end
      while (mq.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_flush(input logic use_ar);
      for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h200 + 4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL clear_pre_%0d count=%0d exp 3", use_ar, count);
      end
      step(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, ~use_ar, use_ar);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || instruction !== NOP || PC_added_ID !== 32'h0) begin
         errors++;
         $display("FAIL clear_%0d count=%0d valid=%b instr=%h pc=%h exp 0/0/%h/0", use_ar, count, out_valid, instruction, PC_added_ID, NOP);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || instruction === 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL clear_word_leak_%0d valid=%b instr=%h exp 0/%h", use_ar, out_valid, instruction, NOP);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h300 + 4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || instruction !== NOP) begin
         errors++;
         $display("FAIL async_rst count=%0d valid=%b ready=%b instr=%h exp 0/0/1/%h", count, out_valid, in_ready, instruction, NOP);
      end
      #1 rst = 1'b0;
      mq.delete();
      @(negedge clk);
      step(1'b1, 32'h400, 32'h0031_0093, 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd1 || PC_added_ID !== 32'h400 || instruction !== 32'h0031_0093 || write_addr_ID !== 5'd1) begin
         errors++;
         $display("FAIL post_rst count=%0d pc=%h instr=%h wa=%0d exp 1/400/00310093/1", count, PC_added_ID, instruction, write_addr_ID);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [31:0] raw;
         raw = m_raw();
         checks++;
         if (out_valid !== m_valid() || in_ready !== (mq.size() < DEPTH) || count !== 3'(mq.size())) begin
            errors++;
            $display("FAIL rnd_status_%0d valid=%b ready=%b count=%0d exp %b/%b/%0d", i, out_valid, in_ready, count, m_valid(), mq.size() < DEPTH, mq.size());
         end
         checks++;
         if (PC_added_ID !== m_pc() || instruction !== (m_valid() ? raw : NOP) || imm_in !== raw ||
             Read_addr_1_ID !== raw[19:15] || Read_addr_2_ID !== raw[24:20] ||
             write_addr_ID !== raw[11:7] || csr_addr_ID !== raw[31:20]) begin
            errors++;
            $display("FAIL rnd_head_%0d pc=%h instr=%h imm=%h exp %h/%h/%h", i, PC_added_ID, instruction, imm_in, m_pc(), m_valid() ? raw : NOP, raw);
         end
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 23) == 0), 1'($urandom_range(0, 31) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_fill_stall();
      test_back_to_back();
      test_flush(1'b0);
      test_flush(1'b1);
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
